adc_stream_capture: RTL and testbench

ADC_STREAM_CAPTURE -- requirements
Module: adc_stream_capture

---
 rtl/adc_stream_capture.sv | 263 ++++++++++++++++++++++++++
 tb/tb_adc_stream_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_capture.sv
// adc_stream_capture
//   Reads one conversion from a serial ADC for each rising edge of trigger.
//   The word can arrive on 1, 2 or 4 SDI lanes. Each word can be block-averaged
//   over 2^a samples. The result goes out through an AXI-Stream FIFO.
//
// Ports
//   aclk, areset   single clock; asynchronous active-high reset
//   trigger        a rising edge starts one readout
//   lane_mode      00 one lane, 01 two lanes, 10 four lanes (11 -> one lane)
//   avg_log2       averaging exponent, clamped to AVG_LOG2_MAX
//   clear_sticky   pulse that clears status[2:1]
//   spi_clk, spi_csn, spi_sdi   serial interface to the ADC
//   m_axis_*       averaged output stream
//   status         [0] active, [1] overflow, [2] missed trigger, [15:8] FIFO level
module adc_stream_capture #(
   parameter int NUM_SDI      = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int SCK_DIV      = 1,
   parameter int AVG_LOG2_MAX = 4,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    trigger,
   input  logic [1:0]              lane_mode,
   input  logic [3:0]              avg_log2,
   input  logic                    clear_sticky,
   output logic                    spi_clk,
   output logic                    spi_csn,
   input  logic [NUM_SDI-1:0]      spi_sdi,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [31:0]             status
);

   localparam int CNT_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam int ACC_W  = DATA_WIDTH + AVG_LOG2_MAX;
   localparam int SCNT_W = AVG_LOG2_MAX + 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = AW + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);
   localparam logic [3:0]       A_MAX    = (AVG_LOG2_MAX > 15) ? 4'd15 : 4'(AVG_LOG2_MAX);
   localparam logic [BIT_W-1:0] LAST1    = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST2    = BIT_W'(DATA_WIDTH / 2 - 1);
   localparam logic [BIT_W-1:0] LAST4    = BIT_W'(DATA_WIDTH / 4 - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    phase;      // 0: low half of sck period, 1: high half
   logic [BIT_W-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0]   sh;
   logic [1:0]              l_sel;      // latched lanes: 0 -> 1, 1 -> 2, 2 -> 4
   logic [3:0]              a_lat;      // latched, clamped averaging exponent
   logic [ACC_W-1:0]        acc;
   logic [SCNT_W-1:0]       scnt;
   logic                    wr_pend;
   logic [DATA_WIDTH-1:0]   wr_word;
   logic                    trig_q;
   logic                    missed;
   logic                    ovf;

   logic [3:0]              sdi_pad;
   logic [1:0]              lane_sel;
   logic [3:0]              a_new;
   logic [BIT_W-1:0]        last_bit;
   logic [DATA_WIDTH-1:0]   next_sh;
   logic [ACC_W-1:0]        acc_sum;
   logic                    blk_last;
   logic                    cnt_last;
   logic                    trig_rise;

   assign cnt_last  = (cnt == CNT_LAST);
   assign trig_rise = trigger & ~trig_q;
   assign a_new     = (avg_log2 > A_MAX) ? A_MAX : avg_log2;

   always_comb begin
      sdi_pad = '0;
      sdi_pad[NUM_SDI-1:0] = spi_sdi;
   end

   // Lane counts the hardware cannot support fall back to a single lane.
   always_comb begin
      lane_sel = 2'd0;
      if (lane_mode == 2'b01 && NUM_SDI >= 2)
         lane_sel = 2'd1;
      else if (lane_mode == 2'b10 && NUM_SDI >= 4)
         lane_sel = 2'd2;
   end

   // sdi[0] carries the MSB of each L-bit group; the word is shifted in MSB first.
   always_comb begin
      case (l_sel)
         2'd1: begin
            next_sh  = {sh[DATA_WIDTH-3:0], sdi_pad[0], sdi_pad[1]};
            last_bit = LAST2;
         end
         2'd2: begin
            next_sh  = {sh[DATA_WIDTH-5:0], sdi_pad[0], sdi_pad[1], sdi_pad[2], sdi_pad[3]};
            last_bit = LAST4;
         end
         default: begin
            next_sh  = {sh[DATA_WIDTH-2:0], sdi_pad[0]};
            last_bit = LAST1;
         end
      endcase
   end

   assign acc_sum  = acc + ACC_W'(next_sh);
   assign blk_last = (scnt == ((SCNT_W'(1) << a_lat) - SCNT_W'(1)));

   // Readout sequencer plus sample accumulation.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state   <= IDLE;
         cnt     <= '0;
         phase   <= 1'b0;
         bit_cnt <= '0;
         spi_clk <= 1'b0;
         spi_csn <= 1'b1;
         sh      <= '0;
         l_sel   <= 2'd0;
         a_lat   <= 4'd0;
         acc     <= '0;
         scnt    <= '0;
         wr_pend <= 1'b0;
         wr_word <= '0;
         trig_q  <= 1'b1;   // a trigger held high through reset is not an edge
         missed  <= 1'b0;
      end else begin
         trig_q  <= trigger;
         wr_pend <= 1'b0;
         if (clear_sticky)
            missed <= 1'b0;
         if (trig_rise && state != IDLE)
            missed <= 1'b1;
         case (state)
            IDLE: begin
               if (trig_rise) begin
                  state   <= SETUP;
                  spi_csn <= 1'b0;
                  cnt     <= '0;
                  l_sel   <= lane_sel;
                  a_lat   <= a_new;
                  // A new block length invalidates any partial sum.
                  if (a_new != a_lat) begin
                     acc  <= '0;
                     scnt <= '0;
                  end
               end
            end
            SETUP: begin
               if (cnt_last) begin
                  state   <= SHIFT;
                  cnt     <= '0;
                  phase   <= 1'b0;
                  bit_cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SHIFT: begin
               if (!cnt_last) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  cnt <= '0;
                  if (!phase) begin
                     phase   <= 1'b1;
                     spi_clk <= 1'b1;
                  end else begin
                     // Last aclk of the high phase: capture the lanes.
                     phase   <= 1'b0;
                     spi_clk <= 1'b0;
                     sh      <= next_sh;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     if (bit_cnt == last_bit) begin
                        state <= HOLD;
                        if (blk_last) begin
                           wr_pend <= 1'b1;
                           wr_word <= DATA_WIDTH'(acc_sum >> a_lat);
                           acc     <= '0;
                           scnt    <= '0;
                        end else begin
                           acc  <= acc_sum;
                           scnt <= scnt + SCNT_W'(1);
                        end
                     end
                  end
               end
            end
            HOLD: begin
               if (cnt_last) begin
                  state   <= IDLE;
                  spi_csn <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output FIFO. The head entry drives tdata directly, so it stays put until popped.
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LVL_W-1:0]      level;
   logic                  fifo_full;
   logic                  rd_en;
   logic                  wr_ok;
   logic [7:0]            lvl8;

   assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
   assign m_axis_tvalid = (level != '0);
   assign m_axis_tdata  = mem[rd_ptr];
   assign rd_en         = m_axis_tvalid & m_axis_tready;
   // A pop in the same cycle makes room for the write even when full.
   assign wr_ok         = wr_pend & (~fifo_full | rd_en);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_word;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_en})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (wr_pend && !wr_ok)
            ovf <= 1'b1;
         else if (clear_sticky)
            ovf <= 1'b0;
      end
   end

   generate
      if (LVL_W > 8) begin : g_lvl_sat
         assign lvl8 = (|level[LVL_W-1:8]) ? 8'hFF : level[7:0];
      end else begin : g_lvl_direct
         assign lvl8 = 8'(level);
      end
   endgenerate

   assign status = {16'd0, lvl8, 5'd0, missed, ovf, (state != IDLE)};

endmodule

// File: tb/tb_adc_stream_capture.sv
module tb_adc_stream_capture;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          aclk = 1'b0;
   logic          areset;
   logic          trigger;
   logic [1:0]    lane_mode;
   logic [3:0]    avg_log2;
   logic          clear_sticky;
   logic          spi_clk;
   logic          spi_csn;
   logic [3:0]    spi_sdi;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [31:0]   status;

   int checks   = 0;
   int failures = 0;

   adc_stream_capture #(
      .NUM_SDI(4), .DATA_WIDTH(DW), .SCK_DIV(2), .AVG_LOG2_MAX(4), .FIFO_DEPTH(DEPTH)
   ) dut (
      .aclk(aclk), .areset(areset), .trigger(trigger), .lane_mode(lane_mode),
      .avg_log2(avg_log2), .clear_sticky(clear_sticky), .spi_clk(spi_clk),
      .spi_csn(spi_csn), .spi_sdi(spi_sdi), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .status(status)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ADC model: presents group idx of adc_word, MSB first, sdi[0] = group MSB.
   logic [31:0] adc_word = '0;
   int          adc_L    = 1;
   int          adc_idx  = 0;
   int          pulses   = 0;

   task automatic adc_drive();
      for (int j = 0; j < 4; j++) begin
         if (j < adc_L && adc_idx < DW / adc_L) begin
            int b;
            b = DW - 1 - adc_idx * adc_L - j;
            spi_sdi[j] = adc_word[b];
         end else begin
            spi_sdi[j] = 1'($urandom);
         end
      end
   endtask

   always @(negedge spi_csn) begin
      #1;
      adc_idx = 0;
      adc_drive();
   end

   always @(negedge spi_clk) begin
      #1;
      if (spi_csn === 1'b0) begin
         adc_idx++;
         adc_drive();
      end
   end

   always @(posedge spi_clk) pulses++;

   // Reference model: samples grouped into blocks of 2^a, mean written in order.
   int          model_a = 0;
   logic [31:0] blk[$];
   logic [31:0] exp_q[$];
   bit          exp_ovf = 0;

   function automatic int lanes_of(input logic [1:0] lm);
      case (lm)
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 1;
      endcase
   endfunction

   function automatic void model_sample(input logic [31:0] w, input logic [3:0] av);
      int a;
      a = (av > 4) ? 4 : int'(av);
      if (a != model_a) begin
         blk.delete();
         model_a = a;
      end
      blk.push_back(w);
      if (blk.size() == (1 << a)) begin
         longint s;
         s = 0;
         foreach (blk[k]) s += longint'(blk[k]);
         blk.delete();
         if (exp_q.size() >= DEPTH)
            exp_ovf = 1;
         else
            exp_q.push_back(32'(s >> a));
      end
   endfunction

   // Stream monitor: order/value of every word and stability while stalled.
   int          rx_count = 0;
   logic [31:0] last_rx  = '0;
   bit          stall_prev = 0;
   logic [31:0] prev_data  = '0;

   always @(negedge aclk) begin
      if (areset !== 1'b0) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            chk("tvalid_hold", m_axis_tvalid, 1);
            chk("tdata_hold", m_axis_tdata, prev_data);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", m_axis_tvalid, 0);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("tdata", m_axis_tdata, e);
               rx_count++;
               last_rx = m_axis_tdata;
            end
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic pulse_trigger();
      @(posedge aclk); #1 trigger = 1'b1;
      @(posedge aclk); #1 trigger = 1'b0;
   endtask

   task automatic wait_csn(input logic v);
      int n;
      n = 0;
      while (spi_csn !== v && n < 5000) begin
         @(posedge aclk); #1;
         n++;
      end
      chk("csn_wait", spi_csn, v);
   endtask

   task automatic wait_pulses(input int p);
      int n;
      n = 0;
      while (pulses < p && n < 2000) begin
         @(posedge aclk); #1;
         n++;
      end
      chk("pulse_wait", (pulses >= p), 1);
   endtask

   task automatic run_readout(input logic [31:0] w, input logic [1:0] lm, input logic [3:0] av);
      adc_word  = w;
      adc_L     = lanes_of(lm);
      lane_mode = lm;
      avg_log2  = av;
      pulses    = 0;
      model_sample(w, av);
      pulse_trigger();
      wait_csn(1'b0);
      wait_csn(1'b1);
      chk("sck_pulses", pulses, DW / adc_L);
      cyc(4);
   endtask

   initial begin
      int          rx0;
      logic [3:0]  av;
      areset        = 1'b1;
      trigger       = 1'b1;   // held high through reset
      lane_mode     = 2'b00;
      avg_log2      = 4'd0;
      clear_sticky  = 1'b0;
      m_axis_tready = 1'b1;
      spi_sdi       = '0;
      cyc(3);
      chk("rst_csn", spi_csn, 1);
      chk("rst_sck", spi_clk, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_status", status, 0);
      areset = 1'b0;
      cyc(6);
      chk("held_trig_no_start", status, 0);
      chk("held_trig_csn", spi_csn, 1);
      trigger = 1'b0;
      cyc(2);

      // Four lanes, one lane, and the illegal mode that falls back to one lane.
      run_readout(32'h8BADF00D, 2'b10, 4'd0);
      chk("four_lane_word", last_rx, 32'h8BADF00D);
      run_readout(32'h0023FF42, 2'b00, 4'd0);
      chk("one_lane_word", last_rx, 32'h0023FF42);
      run_readout(32'h0023FF42, 2'b11, 4'd0);
      chk("mode11_word", last_rx, 32'h0023FF42);
      run_readout($urandom, 2'b01, 4'd0);

      // Averaging of four samples gives a single word.
      rx0 = rx_count;
      run_readout(32'd10, 2'b10, 4'd2);
      run_readout(32'd11, 2'b00, 4'd2);
      run_readout(32'd12, 2'b01, 4'd2);
      run_readout(32'd13, 2'b10, 4'd2);
      cyc(4);
      chk("avg4_count", rx_count - rx0, 1);
      chk("avg4_word", last_rx, 32'h0000000B);

      // Random words, lanes and exponents; exponent changes drop partial blocks.
      av = 4'd0;
      for (int i = 0; i < 24; i++) begin
         if (i % 4 == 0) av = 4'($urandom_range(0, 2));
         run_readout($urandom, 2'($urandom_range(0, 3)), av);
      end
      // Exponent above the maximum clamps to 16-sample blocks.
      rx0 = rx_count;
      for (int i = 0; i < 16; i++) run_readout($urandom, 2'b10, 4'd9);
      cyc(4);
      chk("avg16_count", rx_count - rx0, 1);
      cyc(10);
      chk("drained_before_ovf", exp_q.size(), 0);

      // Fill the FIFO with tready low; the fifth word overflows.
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 5; i++) run_readout(32'(i), 2'b10, 4'd0);
      chk("full_level", status[15:8], DEPTH);
      chk("ovf_flag", status[1], exp_ovf);
      chk("full_head", m_axis_tdata, 32'd1);
      m_axis_tready = 1'b1;
      cyc(10);
      chk("drained_after_ovf", exp_q.size(), 0);
      chk("empty_tvalid", m_axis_tvalid, 0);
      clear_sticky = 1'b1; cyc(1); clear_sticky = 1'b0; cyc(1);
      chk("ovf_cleared", status[1], 0);

      // Trigger during SHIFT is ignored but flagged.
      adc_word = $urandom; adc_L = 1; lane_mode = 2'b00; avg_log2 = 4'd0;
      pulses = 0;
      model_sample(adc_word, 4'd0);
      pulse_trigger();
      wait_pulses(2);
      chk("active_in_shift", status[0], 1);
      pulse_trigger();
      wait_csn(1'b1);
      chk("no_extra_pulses", pulses, 32);
      chk("missed_flag", status[2], 1);
      cyc(8);
      chk("no_extra_readout", spi_csn, 1);
      chk("idle_after", status[0], 0);
      clear_sticky = 1'b1; cyc(1); clear_sticky = 1'b0; cyc(1);
      chk("missed_cleared", status[2], 0);
      cyc(4);

      // Reset at the third sample aborts the readout without output.
      rx0 = rx_count;
      adc_word = $urandom; adc_L = 1; lane_mode = 2'b00; avg_log2 = 4'd0;
      pulses = 0;
      pulse_trigger();
      wait_pulses(3);
      areset = 1'b1;
      #1;
      chk("abort_csn", spi_csn, 1);
      chk("abort_sck", spi_clk, 0);
      chk("abort_status", status, 0);
      chk("abort_tvalid", m_axis_tvalid, 0);
      blk.delete();
      model_a = 0;
      cyc(3);
      areset = 1'b0;
      cyc(100);
      chk("abort_no_word", rx_count - rx0, 0);
      chk("abort_tvalid_late", m_axis_tvalid, 0);

      // First trigger after reset is accepted normally.
      run_readout(32'hC0FFEE01, 2'b10, 4'd0);
      chk("post_reset_word", last_rx, 32'hC0FFEE01);
      cyc(10);
      chk("final_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
